// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code mirror, synchronous load and terminal-count pulse.
// Optional saturating build: define GRAY_COUNTER_SAT_EN to hold at the bounds instead of wrapping.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             valid
);

    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Gray code of a binary value: each bit is the XOR of itself and its upper neighbour.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ {1'b0, b[WIDTH-1:1]};
    endfunction

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic             valid_q, valid_d;
    logic             at_max_s, at_zero_s;

    // Next-state: load beats count beats hold; gray always derives from the next binary value.
    always_comb begin
        bin_d     = bin_q;
        tc_d      = 1'b0;
        valid_d   = 1'b1;
        at_max_s  = (bin_q == MAX_C);
        at_zero_s = (bin_q == ZERO_C);
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up_dn) begin
`ifdef GRAY_COUNTER_SAT_EN
                if (at_max_s) begin
                    bin_d = bin_q;
                    tc_d  = 1'b1;
                end else begin
                    bin_d = bin_q + ONE_C;
                end
`else
                bin_d = bin_q + ONE_C;
                tc_d  = at_max_s;
`endif
            end else begin
`ifdef GRAY_COUNTER_SAT_EN
                if (at_zero_s) begin
                    bin_d = bin_q;
                    tc_d  = 1'b1;
                end else begin
                    bin_d = bin_q - ONE_C;
                end
`else
                bin_d = bin_q - ONE_C;
                tc_d  = at_zero_s;
`endif
            end
        end else begin
            bin_d = bin_q;
        end
        gray_d = bin2gray(bin_d);
    end

    // State registers; reset clears everything without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= ZERO_C;
            gray_q  <= ZERO_C;
            tc_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            tc_q    <= tc_d;
            valid_q <= valid_d;
        end
    end

    assign bin   = bin_q;
    assign gray  = gray_q;
    assign tc    = tc_q;
    assign valid = valid_q;

endmodule
